// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage in front of a combinational instruction ROM.
// The unit owns the program counter, drives it to the ROM and registers the
// decoded ROM fields into an instruction register (IR) for decode/execute.
// It handles start, stall, branch redirect with a one-cycle flush, halt
// detection and a saturating fetch counter.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             leave IDLE/HALT and fetch from RESET_PC (ignored in RUN)
//   stall             freeze PC, IR and counter for this edge
//   branch_taken      redirect request from execute
//   branch_rel        1: target = ir_pc + branch_target, 0: absolute target
//   branch_target     absolute address or two's-complement offset
//   rom_*             decoded ROM word at pc_out (same cycle)
//   pc_out            program counter to the ROM
//   ir_valid, ir_*    registered instruction and its address ir_pc
//   running, halted   state == RUN / state == HALT
//   fetch_count       valid instructions latched since last start (saturates)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                     PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [3:0]             HALT_OPCODE = 4'hB
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic                branch_rel,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                rom_format,
  input  logic [3:0]          rom_opcode,
  input  logic                rom_sign,
  input  logic [2:0]          rom_operand,
  input  logic [7:0]          rom_immediate,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                ir_valid,
  output logic                ir_format,
  output logic [3:0]          ir_opcode,
  output logic                ir_sign,
  output logic [2:0]          ir_operand,
  output logic [7:0]          ir_immediate,
  output logic [PC_WIDTH-1:0] ir_pc,
  output logic                running,
  output logic                halted,
  output logic [15:0]         fetch_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic       format;
    logic [3:0] opcode;
    logic       sign;
    logic [2:0] operand;
    logic [7:0] immediate;
  } instr_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   ir_pc_q, ir_pc_d;
  instr_t                ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic [15:0]           count_q, count_d;

  instr_t                rom_word;
  logic                  rom_is_halt;
  logic [PC_WIDTH-1:0]   branch_dest;
  logic [15:0]           count_inc;

  assign rom_word    = '{format:    rom_format,
                         opcode:    rom_opcode,
                         sign:      rom_sign,
                         operand:   rom_operand,
                         immediate: rom_immediate};
  assign rom_is_halt = rom_format && (rom_opcode == HALT_OPCODE);

  // Relative targets are taken from the instruction currently in IR (the
  // branch being executed), not from pc_out which is already one ahead.
  assign branch_dest = branch_rel ? (ir_pc_q + branch_target) : branch_target;

  assign count_inc   = (count_q == 16'hFFFF) ? count_q : (count_q + 16'd1);

  // Next-state and datapath control.
  // NOTE: every signal gets a default before the case statement so no path
  // leaves one unassigned; otherwise synthesis would infer latches.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_pc_d    = ir_pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;

    unique case (state_q)
      IDLE: begin
        ir_valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          count_d = '0;
        end
      end

      RUN: begin
        if (stall) begin
          // Full hold; a pending branch is re-presented once stall drops.
        end else if (branch_taken) begin
          pc_d       = branch_dest;
          ir_valid_d = 1'b0;
        end else begin
          ir_d       = rom_word;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          count_d    = count_inc;
          if (rom_is_halt) begin
            // PC stays on the halt word so the halt address stays visible.
            state_d = HALT;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end
      end

      HALT: begin
        ir_valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
          count_d = '0;
        end
      end

      default: begin
        state_d    = IDLE;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is written with non-blocking assignments in a single clocked
  // process with asynchronous reset, so all registers update together and
  // reset takes effect immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_pc_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_pc_q    <= ir_pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      count_q    <= count_d;
    end
  end

  assign pc_out       = pc_q;
  assign ir_valid     = ir_valid_q;
  assign ir_format    = ir_q.format;
  assign ir_opcode    = ir_q.opcode;
  assign ir_sign      = ir_q.sign;
  assign ir_operand   = ir_q.operand;
  assign ir_immediate = ir_q.immediate;
  assign ir_pc        = ir_pc_q;
  assign running      = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed testbench for fetch_unit. A small ROM model drives a word derived
// from the address (never a halt word) except at address 120, which holds a
// halt instruction while halt_en is set. Inputs change 1 ns after a rising
// edge; outputs are compared at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PC_WIDTH = 16;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                stall;
  logic                branch_taken;
  logic                branch_rel;
  logic [PC_WIDTH-1:0] branch_target;
  logic                rom_format;
  logic [3:0]          rom_opcode;
  logic                rom_sign;
  logic [2:0]          rom_operand;
  logic [7:0]          rom_immediate;
  logic [PC_WIDTH-1:0] pc_out;
  logic                ir_valid;
  logic                ir_format;
  logic [3:0]          ir_opcode;
  logic                ir_sign;
  logic [2:0]          ir_operand;
  logic [7:0]          ir_immediate;
  logic [PC_WIDTH-1:0] ir_pc;
  logic                running;
  logic                halted;
  logic [15:0]         fetch_count;

  logic                halt_en;
  int                  checks;
  int                  errors;

  fetch_unit #(
    .PC_WIDTH    (PC_WIDTH),
    .RESET_PC    (16'h0000),
    .HALT_OPCODE (4'hB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_rel    (branch_rel),
    .branch_target (branch_target),
    .rom_format    (rom_format),
    .rom_opcode    (rom_opcode),
    .rom_sign      (rom_sign),
    .rom_operand   (rom_operand),
    .rom_immediate (rom_immediate),
    .pc_out        (pc_out),
    .ir_valid      (ir_valid),
    .ir_format     (ir_format),
    .ir_opcode     (ir_opcode),
    .ir_sign       (ir_sign),
    .ir_operand    (ir_operand),
    .ir_immediate  (ir_immediate),
    .ir_pc         (ir_pc),
    .running       (running),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: format 0 everywhere except the halt word at 120.
  always_comb begin
    rom_format    = 1'b0;
    rom_opcode    = pc_out[3:0];
    rom_sign      = pc_out[4];
    rom_operand   = pc_out[7:5];
    rom_immediate = pc_out[15:8] ^ pc_out[7:0];
    if (halt_en && pc_out == 16'd120) begin
      rom_format    = 1'b1;
      rom_opcode    = 4'hB;
      rom_sign      = 1'b0;
      rom_operand   = 3'b000;
      rom_immediate = 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the core fetch-visible outputs in one call.
  task automatic check_core(input string tag, input logic [15:0] e_pc, input logic e_valid,
                            input logic [15:0] e_ir_pc, input logic [15:0] e_cnt);
    check({tag, ".pc_out"},      32'(pc_out),      32'(e_pc));
    check({tag, ".ir_valid"},    32'(ir_valid),    32'(e_valid));
    check({tag, ".ir_pc"},       32'(ir_pc),       32'(e_ir_pc));
    check({tag, ".fetch_count"}, 32'(fetch_count), 32'(e_cnt));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    halt_en       = 1'b1;
    rst_n         = 1'b0;
    start         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_rel    = 1'b0;
    branch_target = '0;

    // Reset values.
    #2;
    check_core("reset", 16'h0000, 1'b0, 16'h0000, 16'd0);
    check("reset.running", 32'(running), 32'd0);
    check("reset.halted",  32'(halted),  32'd0);
    check("reset.ir_fields",
          32'({ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate}), 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // First edge after release: still IDLE, nothing moves without start.
    step();
    check_core("idle", 16'h0000, 1'b0, 16'h0000, 16'd0);
    check("idle.running", 32'(running), 32'd0);

    // Start: running after edge k, first valid IR after edge k+1.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start.running", 32'(running), 32'd1);
    check_core("start", 16'h0000, 1'b0, 16'h0000, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_core($sformatf("seq%0d", i), 16'(i + 1), 1'b1, 16'(i), 16'(i + 1));
    end
    check("seq.ir_opcode", 32'(ir_opcode), 32'h3);
    step();
    check_core("seq4", 16'd5, 1'b1, 16'd4, 16'd5);

    // Stall for 3 cycles at pc_out=5; branch asserted during the stall is ignored.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_taken  = (i == 1);
      branch_target = 16'h0040;
      step();
      check_core($sformatf("stall%0d", i), 16'd5, 1'b1, 16'd4, 16'd5);
    end
    stall        = 1'b0;
    branch_taken = 1'b0;
    step();
    check_core("unstall", 16'd6, 1'b1, 16'd5, 16'd6);

    // Run on until IR holds address 10.
    for (int i = 0; i < 5; i++) step();
    check_core("pre_branch", 16'd11, 1'b1, 16'd10, 16'd11);

    // Absolute branch to 0x40: one bubble, then target in IR.
    branch_taken  = 1'b1;
    branch_rel    = 1'b0;
    branch_target = 16'h0040;
    step();
    branch_taken  = 1'b0;
    check_core("abs_bubble", 16'h0040, 1'b0, 16'd10, 16'd11);
    step();
    check_core("abs_target", 16'h0041, 1'b1, 16'h0040, 16'd12);
    check("abs_target.ir_immediate", 32'(ir_immediate), 32'h40);

    // Get back to ir_pc=10, then relative branch by -4.
    branch_taken  = 1'b1;
    branch_target = 16'd10;
    step();
    branch_taken  = 1'b0;
    step();
    check_core("back10", 16'd11, 1'b1, 16'd10, 16'd13);
    branch_taken  = 1'b1;
    branch_rel    = 1'b1;
    branch_target = 16'hFFFC;
    step();
    branch_taken  = 1'b0;
    branch_rel    = 1'b0;
    check_core("rel_bubble", 16'd6, 1'b0, 16'd10, 16'd13);
    step();
    check_core("rel_target", 16'd7, 1'b1, 16'd6, 16'd14);

    // Halt word at 120.
    branch_taken  = 1'b1;
    branch_target = 16'd118;
    step();
    branch_taken  = 1'b0;
    step();
    step();
    check_core("pre_halt", 16'd120, 1'b1, 16'd119, 16'd16);
    step();
    check_core("halt_edge", 16'd120, 1'b1, 16'd120, 16'd17);
    check("halt_edge.halted",    32'(halted),    32'd1);
    check("halt_edge.running",   32'(running),   32'd0);
    check("halt_edge.ir_opcode", 32'(ir_opcode), 32'hB);
    check("halt_edge.ir_format", 32'(ir_format), 32'd1);
    step();
    check_core("halt_after", 16'd120, 1'b0, 16'd120, 16'd17);
    step();
    check("halt_hold.pc_out", 32'(pc_out), 32'd120);
    check("halt_hold.halted", 32'(halted), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check_core("restart", 16'h0000, 1'b0, 16'd120, 16'd0);
    check("restart.running", 32'(running), 32'd1);
    check("restart.halted",  32'(halted),  32'd0);

    // PC wrap from 0xFFFF.
    branch_taken  = 1'b1;
    branch_target = 16'hFFFF;
    step();
    branch_taken  = 1'b0;
    check_core("wrap_bubble", 16'hFFFF, 1'b0, 16'd120, 16'd0);
    step();
    check_core("wrap", 16'h0000, 1'b1, 16'hFFFF, 16'd1);

    // start while RUN is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    check_core("start_in_run", 16'h0001, 1'b1, 16'h0000, 16'd2);
    check("start_in_run.running", 32'(running), 32'd1);

    // Counter saturation: 65533 more fetches reach 0xFFFF, extras hold there.
    halt_en = 1'b0;
    for (int i = 0; i < 65540; i++) step();
    check("saturate.fetch_count", 32'(fetch_count), 32'hFFFF);
    check("saturate.running",     32'(running),     32'd1);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_core("async_rst", 16'h0000, 1'b0, 16'h0000, 16'd0);
    check("async_rst.running", 32'(running), 32'd0);
    check("async_rst.ir_fields",
          32'({ir_format, ir_opcode, ir_sign, ir_operand, ir_immediate}), 32'd0);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check_core("post_rst_idle", 16'h0000, 1'b0, 16'h0000, 16'd0);
    check("post_rst_idle.running", 32'(running), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the combinational instruction ROM. Owns the program counter and drives the ROM's 16-bit PC input. Each non-stalled cycle it registers the ROM's decoded fields (format, opcode, sign, operand, immediate) into an instruction register for the decode/execute stage. Handles start, stall, branch redirect with flush, halt detection, and a fetch counter.

## Interface
- PC_WIDTH, 16, width of PC and branch target
- RESET_PC, 16'h0000, PC loaded on reset and on start
- HALT_OPCODE, 4'hB, opcode that halts fetch when format=1
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  leave IDLE/HALT and begin fetching at RESET_PC
- stall  in  1  hold PC, IR and counter unchanged
- branch_taken  in  1  redirect request from execute
- branch_rel  in  1  1: target = ir_pc + branch_target; 0: absolute
- branch_target  in  PC_WIDTH  absolute address or two's-complement offset
- rom_format, rom_opcode[3:0], rom_sign, rom_operand[2:0], rom_immediate[7:0]  in  ROM outputs for pc_out
- pc_out  out  PC_WIDTH  to ROM pc_in
- ir_valid  out  1  IR holds a real instruction
- ir_format, ir_opcode[3:0], ir_sign, ir_operand[2:0], ir_immediate[7:0]  out  registered instruction fields
- ir_pc  out  PC_WIDTH  address of the instruction in IR
- running  out  1  state == RUN
- halted  out  1  state == HALT
- fetch_count  out  16  instructions latched with ir_valid=1 since last start

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE.
- Reset values: pc_out=RESET_PC, all ir_* fields 0, ir_valid=0, ir_pc=0, running=0, halted=0, fetch_count=0.
- IDLE: PC held, ir_valid=0. start=1 -> RUN, PC<=RESET_PC, fetch_count<=0.
- RUN priority per edge: stall > branch_taken > halt detect > normal.
  - stall=1: no register changes (branch_taken ignored; execute holds it until stall drops).
  - branch_taken=1: PC<=target (absolute, or ir_pc+branch_target modulo 2^PC_WIDTH); ir_valid<=0 (wrong-path fetch flushed); counter unchanged.
  - ROM word is halt (rom_format=1, rom_opcode=HALT_OPCODE): IR latches it, ir_valid<=1, ir_pc<=pc_out, counter+1, PC unchanged, state->HALT.
  - normal: IR latches ROM fields, ir_pc<=pc_out, ir_valid<=1, PC<=PC+1 (0xFFFF wraps to 0x0000), counter+1.
- HALT: ir_valid<=0 on first HALT edge; PC frozen at halt address; start=1 -> RUN at RESET_PC, counter cleared.
- start while RUN: ignored.
- fetch_count saturates at 16'hFFFF.
- rst_n low at any time: immediate return to reset values, independent of clk.

## Timing
- ROM is combinational: rom_* valid the same cycle as pc_out; IR captures on the next rising edge.
- start at edge k -> running=1, pc_out=RESET_PC after k; first ir_valid=1 after edge k+1.
- Steady state: one instruction per cycle, IR lags pc_out by exactly one address.
- Branch at edge b: one bubble (ir_valid=0 after b); target instruction in IR after b+1.
- Halt word fetched at edge h: halt instruction in IR after h, halted=1 after h, ir_valid=0 after h+1.
- Stall: zero-latency hold; releasing stall resumes on the same edge.
- rst_n deassertion synchronised externally; first active edge after release treated as IDLE.

## Test plan
- Reset then start with ROM words 0..4 non-halt -> ir_pc sequence 0,1,2,3, ir_valid=1 from second edge, fetch_count=4 after 5 edges.
- Stall held 3 cycles at pc_out=5 -> pc_out, ir_*, fetch_count unchanged for 3 cycles, resume to pc_out=6 next edge.
- Absolute branch to 16'h0040 while ir_pc=10 -> one cycle ir_valid=0, then ir_pc=0x40; relative with branch_target=16'hFFFC at ir_pc=10 -> next ir_pc=6.
- ROM returns 9'b110110000 at pc=120 -> IR opcode=4'hB, halted=1, pc_out stays 120, ir_valid=0 next cycle; start -> pc_out=0, fetch_count=0.
- PC at 16'hFFFF normal fetch -> pc_out wraps to 0; stall and branch_taken together -> stall wins, no redirect.
- rst_n pulled low mid-RUN between edges -> all outputs to reset values immediately; state IDLE, start required to resume.
